// File: rtl/alu_muldiv.sv
// RV M-extension execution unit: multiply (fast or iterative shift-add) and
// restoring divide on unsigned magnitudes, with sign fix-up and RISC-V corner results.
module alu_muldiv #(
    parameter int  XLEN     = 32,
    parameter bit  FAST_MUL = 1'b1,
    localparam int CNT_W    = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   hi_q, lo_q, b_q;
    logic              valid_q;

    // Final result selection; hi/lo hold {remainder, quotient} or {product_hi, product_lo}.
    function automatic logic [XLEN-1:0] fix_sign(input logic [2:0] op, input logic neg,
                                                 input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   v;
        p = {hi, lo};
        if (neg) p = -p;
        v = op[1] ? hi : lo;
        if (neg) v = -v;
        if (op[2])
            return v;
        else if (op == OP_MUL)
            return p[XLEN-1:0];
        else
            return p[2*XLEN-1:XLEN];
    endfunction

    logic              is_div, sgn1, sgn2, s1, s2, neg, div0, ovf, fast;
    logic [XLEN-1:0]   mag1, mag2, fast_res;
    logic [2*XLEN-1:0] prod_fast;

    always_comb begin
        is_div = op_i[2];
        sgn1   = !(op_i inside {OP_MULHU, OP_DIVU, OP_REMU});
        sgn2   = op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        s1     = sgn1 & op1_i[XLEN-1];
        s2     = sgn2 & op2_i[XLEN-1];
        mag1   = s1 ? -op1_i : op1_i;
        mag2   = s2 ? -op2_i : op2_i;
        // Remainder takes the dividend's sign; everything else s1^s2.
        neg    = (is_div && op_i[1]) ? s1 : (s1 ^ s2);
        div0   = is_div && (op2_i == '0);
        ovf    = is_div && !op_i[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op2_i);
        fast   = div0 || ovf || (!is_div && FAST_MUL);
        prod_fast = '0;
        if (FAST_MUL)
            prod_fast = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        if (div0)
            fast_res = op_i[1] ? op1_i : '1;
        else if (ovf)
            fast_res = op_i[1] ? '0 : op1_i;
        else
            fast_res = fix_sign(op_i, neg, prod_fast[2*XLEN-1:XLEN], prod_fast[XLEN-1:0]);
    end

    // One radix-2 step. In IDLE the step is fed from the incoming operands so the
    // first step happens on the start edge itself.
    logic            cur_div;
    logic [XLEN-1:0] cur_hi, cur_lo, cur_b, nhi, nlo;
    logic [XLEN:0]   rem_sh, diff, sum;
    logic            ge;

    always_comb begin
        cur_div = (state == IDLE) ? is_div : op_q[2];
        cur_hi  = (state == IDLE) ? '0     : hi_q;
        cur_lo  = (state == IDLE) ? mag1   : lo_q;
        cur_b   = (state == IDLE) ? mag2   : b_q;
        rem_sh  = {cur_hi, cur_lo[XLEN-1]};
        diff    = rem_sh - {1'b0, cur_b};
        ge      = rem_sh >= {1'b0, cur_b};
        sum     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
        if (cur_div) begin
            nhi = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            nlo = {cur_lo[XLEN-2:0], ge};
        end else begin
            nhi = sum[XLEN:1];
            nlo = {sum[0], cur_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            valid_q   <= 1'b0;
            busy_o    <= 1'b0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start_i && !flush_i) begin
                        op_q      <= op_i;
                        neg_q     <= neg;
                        rd_addr_o <= rd_addr_i;
                        busy_o    <= 1'b1;
                        if (fast) begin
                            result_o <= fast_res;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            hi_q  <= nhi;
                            lo_q  <= nlo;
                            b_q   <= mag2;
                            cnt   <= '0;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (flush_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        hi_q <= nhi;
                        lo_q <= nlo;
                        if (cnt == CNT_W'(XLEN-2))
                            state <= FIX;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (flush_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        result_o <= fix_sign(op_q, neg_q, hi_q, lo_q);
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A flush landing on the DONE cycle kills the pulse combinationally.
    assign valid_o = valid_q && !flush_i;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: vector table on fast- and iterative-multiply
// instances, plus hand sequences for flush, ignored start and async reset.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_f = 1'b0, start_s = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  tag = '0;
    logic        busy_f, valid_f, busy_s, valid_s;
    logic [31:0] res_f, res_s;
    logic [4:0]  rd_f, rd_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(32), .FAST_MUL(1'b1)) dut_f (
        .clk(clk), .rst(rst), .start_i(start_f), .op_i(op), .op1_i(a), .op2_i(b),
        .rd_addr_i(tag), .flush_i(flush), .busy_o(busy_f), .valid_o(valid_f),
        .result_o(res_f), .rd_addr_o(rd_f));

    alu_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) dut_s (
        .clk(clk), .rst(rst), .start_i(start_s), .op_i(op), .op1_i(a), .op2_i(b),
        .rd_addr_i(tag), .flush_i(flush), .busy_o(busy_s), .valid_o(valid_s),
        .result_o(res_s), .rd_addr_o(rd_s));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op and wait (bounded) for valid_o. lat = cycles from start to valid, -1 on timeout.
    task automatic do_op(input bit slow, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, output logic [31:0] r, output int lat, output logic [4:0] rt);
        op = o; a = x; b = y; tag = t;
        if (slow) start_s = 1'b1; else start_f = 1'b1;
        tick();
        start_s = 1'b0; start_f = 1'b0;
        op = '0; a = '0; b = '0; tag = '0;
        lat = -1; r = 'x; rt = 'x;
        for (int i = 1; i <= 100; i++) begin
            if (slow ? valid_s : valid_f) begin
                lat = i;
                r   = slow ? res_s : res_f;
                rt  = slow ? rd_s : rd_f;
                break;
            end
            tick();
        end
        tick();
    endtask

    typedef struct {
        bit          slow;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [31:0] r, prev;
        logic [4:0]  rt;
        int          lat, seen;

        vecs[0]  = '{0, 3'b100, 32'hFFFF_FFF9, 32'h2,         5'd1,  32'hFFFF_FFFD, 33};
        vecs[1]  = '{0, 3'b110, 32'hFFFF_FFF9, 32'h2,         5'd2,  32'hFFFF_FFFF, 33};
        vecs[2]  = '{0, 3'b101, 32'h64,        32'h0,         5'd3,  32'hFFFF_FFFF, 1};
        vecs[3]  = '{0, 3'b111, 32'h64,        32'h0,         5'd4,  32'h64,        1};
        vecs[4]  = '{0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 1};
        vecs[5]  = '{0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0,         1};
        vecs[6]  = '{0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h1,         1};
        vecs[7]  = '{0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0,         1};
        vecs[8]  = '{0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 1};
        vecs[10] = '{1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h1,         33};
        vecs[11] = '{1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0,         33};
        vecs[12] = '{1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFF, 33};
        vecs[13] = '{1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE, 33};
        vecs[14] = '{0, 3'b101, 32'd1000,      32'd3,         5'd15, 32'd333,       33};
        vecs[15] = '{0, 3'b111, 32'd1000,      32'd3,         5'd16, 32'd1,         33};
        vecs[16] = '{0, 3'b100, 32'd100,       32'hFFFF_FFF9, 5'd17, 32'hFFFF_FFF2, 33};
        vecs[17] = '{0, 3'b110, 32'd100,       32'hFFFF_FFF9, 5'd18, 32'd2,         33};
        vecs[18] = '{1, 3'b000, 32'd12345,     32'hFFFF_FFFD, 5'd19, 32'hFFFF_6F55, 33};
        vecs[19] = '{0, 3'b000, 32'd12345,     32'hFFFF_FFFD, 5'd20, 32'hFFFF_6F55, 1};

        #3;
        chk("rst_busy",   {31'd0, busy_f},  32'd0);
        chk("rst_valid",  {31'd0, valid_f}, 32'd0);
        chk("rst_result", res_f,            32'd0);
        chk("rst_rd",     {27'd0, rd_f},    32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_op(vecs[i].slow, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, r, lat, rt);
            chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_rd", i), {27'd0, rt}, {27'd0, vecs[i].tag});
        end

        // Fast path: busy for exactly one cycle
        op = 3'b101; a = 32'h64; b = 32'h0; tag = 5'd21; start_f = 1'b1;
        tick();
        start_f = 1'b0;
        chk("fast_busy_c1",  {31'd0, busy_f},  32'd1);
        chk("fast_valid_c1", {31'd0, valid_f}, 32'd1);
        tick();
        chk("fast_busy_c2",  {31'd0, busy_f},  32'd0);
        chk("fast_valid_c2", {31'd0, valid_f}, 32'd0);
        tick();

        // Flush in DONE suppresses valid_o in that same cycle
        op = 3'b100; a = 32'h8000_0000; b = 32'hFFFF_FFFF; start_f = 1'b1;
        tick();
        start_f = 1'b0; flush = 1'b1;
        #1;
        chk("flush_done_valid", {31'd0, valid_f}, 32'd0);
        tick();
        flush = 1'b0;
        tick();

        // Flush at step 10 of DIVU 1000/3
        prev = res_f;
        op = 3'b101; a = 32'd1000; b = 32'd3; tag = 5'd7; start_f = 1'b1;
        tick();
        start_f = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy_f}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_f) seen++;
            tick();
        end
        chk("flush_no_valid", seen, 0);
        chk("flush_result_held", res_f, prev);
        do_op(0, 3'b101, 32'd1000, 32'd3, 5'd9, r, lat, rt);
        chk("after_flush_result", r, 32'd333);
        chk("after_flush_rd", {27'd0, rt}, 32'd9);
        chk("after_flush_latency", lat, 33);

        // Start re-pulsed at step 5 of a DIV is ignored
        op = 3'b100; a = 32'd100; b = 32'hFFFF_FFF9; tag = 5'd3; start_f = 1'b1;
        tick();
        start_f = 1'b0;
        repeat (4) tick();
        op = 3'b101; a = 32'd5; b = 32'd1; tag = 5'd20; start_f = 1'b1;
        tick();
        start_f = 1'b0;
        lat = -1;
        for (int i = 6; i <= 100; i++) begin
            if (valid_f) begin lat = i; break; end
            tick();
        end
        chk("restart_latency", lat, 33);
        chk("restart_result", res_f, 32'hFFFF_FFF2);
        chk("restart_rd", {27'd0, rd_f}, 32'd3);
        tick(); tick();

        // Async reset mid-ITER clears outputs before the next edge
        op = 3'b101; a = 32'd1000; b = 32'd3; tag = 5'd11; start_f = 1'b1;
        tick();
        start_f = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",   {31'd0, busy_f},  32'd0);
        chk("arst_valid",  {31'd0, valid_f}, 32'd0);
        chk("arst_result", res_f,            32'd0);
        chk("arst_rd",     {27'd0, rd_f},    32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_f || busy_f) seen++;
            tick();
        end
        chk("arst_no_valid", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised RV M-extension execution unit beside the combinational ALU in the execute stage.
- Performs MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU on XLEN-bit operands.
- Division is always iterative. Multiply is either one-cycle or iterative, selected by a parameter.
- Pipeline control stalls on busy_o and retires the result on the valid_o pulse, carrying the destination register tag.

Parameters:
- XLEN, 32: operand/result width, must be even and at least 8.
- FAST_MUL, 1: 1 = multiply completes via the 1-cycle fast path; 0 = iterative shift-add multiply, XLEN steps.
- CNT_W, $clog2(XLEN)+1: step counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  launch request, sampled only in IDLE
- op_i  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1_i  in  XLEN  rs1 value (multiplicand/dividend)
- op2_i  in  XLEN  rs2 value (multiplier/divisor)
- rd_addr_i  in  5  destination register tag
- flush_i  in  1  abort the current operation (branch/jump flush)
- busy_o  out  1  operation accepted and not yet completed
- valid_o  out  1  one-cycle result pulse
- result_o  out  XLEN  result, held stable until the next accepted start
- rd_addr_o  out  5  tag captured at start, held alongside result_o

Behaviour:
- Reset (async):
  - state=IDLE; busy_o=0, valid_o=0, result_o=0, rd_addr_o=0.
  - Internal counter, remainder and quotient registers all cleared.
  - Reset asserted mid-operation clears everything immediately; no valid_o follows.
- States:
  - IDLE: a start at edge E0 captures op, operand magnitudes, sign flags and tag.
  - FAST path: E0 -> DONE. Latency 1; valid_o is high in the cycle after E0. Used for:
    - divisor==0;
    - signed overflow (DIV/REM with op1 = most-negative, op2 = -1);
    - any multiply when FAST_MUL=1.
  - Iterative path: E0 -> ITER (counter=0).
    - One radix-2 step per edge: restoring divide, or shift-add multiply.
    - After XLEN steps -> FIX (sign correction, result registered) -> DONE.
    - Latency XLEN+1.
  - DONE: valid_o=1 for exactly one cycle, then -> IDLE.
    - A start in this cycle is ignored; earliest accepted start is in the cycle after valid_o.
- busy_o is high in ITER, FIX and DONE. It is low in IDLE and in the cycle after a flush.
- Signed ops:
  - Core always operates on unsigned magnitudes of signed operands.
  - Quotient sign = s1 XOR s2. Remainder sign = s1 (sign of dividend).
  - MUL low word and MULH high word use the 2*XLEN product, negated when s1 XOR s2.
  - MULHSU treats only op1 as signed. MULHU/DIVU/REMU treat both operands as unsigned.
- Fixed results (RISC-V):
  - x/0: quotient = all ones, remainder = op1.
  - Signed overflow: quotient = op1, remainder = 0.
- flush_i:
  - In ITER/FIX/DONE: next state IDLE; valid_o is suppressed (forced 0 in that same cycle if in DONE); result_o keeps its previous value.
  - Flush and start in the same IDLE cycle: flush wins and the start is dropped.
- start_i while busy_o=1 is ignored; operands are not re-sampled.
- op1_i/op2_i/op_i need only be valid in the start cycle.

Test Plan:
- DIV -7 (0xFFFFFFF9) / 2 (0x00000002), XLEN=32 -> valid_o at cycle 33 after start; result 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
- DIVU 0x64/0 -> 0xFFFFFFFF at latency 1. REMU 0x64/0 -> 0x00000064. busy_o high for exactly 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM of the same -> 0x00000000, both at latency 1.
- Operands 0xFFFFFFFF x 0xFFFFFFFF, FAST_MUL=1 then 0:
  - MUL -> 0x00000001; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE.
  - Latency 1 (FAST_MUL=1) and 33 (FAST_MUL=0).
- DIVU 1000/3 with flush_i pulsed at step 10 -> busy_o=0 next cycle, no valid_o. A new start (DIVU 1000/3) is then accepted and yields 333 with rd_addr_o equal to the new tag.
- Start pulsed again at step 5 of a DIV (ignored, original result delivered). Async rst mid-ITER -> all outputs 0 before the next edge, no valid_o.
